// File: rtl/return_stack.sv
// Return-address LIFO beside the PC path: push on jal, pop on jst with zero-latency top-of-stack read.
// Define RSTACK_WRAP_EN to make a push while full overwrite the oldest entry (circular) instead of being dropped.
module return_stack #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  top;

  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [PTR_W-1:0]  sp_nxt;
  logic [PTR_W:0]    count_nxt;
  logic              ovf_set;
  logic              udf_set;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_ONE;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return p - PTR_ONE;
  endfunction

  assign top      = ptr_dec(sp);
  assign empty    = (count == '0);
  assign full     = (count == CNT_MAX);
  // Read the pre-edge top so the PC mux captures it on the same edge the pop retires it.
  assign data_out = empty ? '0 : mem[top];

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sp;
    sp_nxt    = sp;
    count_nxt = count;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          mem_we    = 1'b1;
          sp_nxt    = ptr_inc(sp);
          count_nxt = count + CNT_ONE;
        end else begin
          ovf_set = 1'b1;
`ifdef RSTACK_WRAP_EN
          mem_we  = 1'b1;
          sp_nxt  = ptr_inc(sp);
`endif
        end
      end
      2'b01: begin
        if (!empty) begin
          sp_nxt    = ptr_dec(sp);
          count_nxt = count - CNT_ONE;
        end else begin
          udf_set = 1'b1;
        end
      end
      2'b11: begin
        mem_we = 1'b1;
        if (!empty) begin
          mem_waddr = top;
        end else begin
          // Pop on empty still lets the paired push land.
          udf_set   = 1'b1;
          sp_nxt    = ptr_inc(sp);
          count_nxt = count + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      count     <= count_nxt;
      overflow  <= overflow | ovf_set;
      underflow <= underflow | udf_set;
    end
  end

  // Storage is never cleared; stale entries are hidden by the empty mask on data_out.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= data_in;
    end
  end

endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: directed plan then randomized push/pop/reset traffic vs a queue model.
module tb_return_stack;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic [PTR_W:0]    count;
  logic              empty, full, overflow, underflow;

  return_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                cnt;
    bit                e, f, o, u;
    int                id;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] mdl[$];
  bit                m_ovf = 0, m_udf = 0;
  int                step_id = 0;
  int                checks = 0;
  int                failures = 0;
  bit                done = 0;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, id, act, want);
    end
  endtask

  // Drive one cycle of strobes and record the state expected right after the edge.
  task automatic step(input bit r, input bit ps, input bit pp, input logic [DATA_W-1:0] din);
    exp_t e;
    @(negedge clk);
    #2;
    reset = r; push = ps; pop = pp; data_in = din;
    if (r) begin
      mdl.delete(); m_ovf = 0; m_udf = 0;
    end else if (ps && pp) begin
      if (mdl.size() == 0) begin
        m_udf = 1; mdl.push_back(din);
      end else begin
        mdl[mdl.size()-1] = din;
      end
    end else if (ps) begin
      if (mdl.size() == DEPTH) begin
        m_ovf = 1;
`ifdef RSTACK_WRAP_EN
        void'(mdl.pop_front());
        mdl.push_back(din);
`endif
      end else begin
        mdl.push_back(din);
      end
    end else if (pp) begin
      if (mdl.size() == 0) m_udf = 1;
      else void'(mdl.pop_back());
    end
    e.d   = (mdl.size() == 0) ? '0 : mdl[mdl.size()-1];
    e.cnt = mdl.size();
    e.e   = (mdl.size() == 0);
    e.f   = (mdl.size() == DEPTH);
    e.o   = m_ovf;
    e.u   = m_udf;
    e.id  = step_id;
    step_id++;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data_out",  e.id, 64'(data_out),  64'(e.d));
        chk("count",     e.id, 64'(count),     64'(e.cnt));
        chk("empty",     e.id, 64'(empty),     64'(e.e));
        chk("full",      e.id, 64'(full),      64'(e.f));
        chk("overflow",  e.id, 64'(overflow),  64'(e.o));
        chk("underflow", e.id, 64'(underflow), 64'(e.u));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    if (!done) begin
      $display("FAIL watchdog step=%0d got=timeout want=finish", step_id);
      $fatal(1, "watchdog expired");
    end
  end

  initial begin : driver
    int mode;
    // Reset then idle.
    step(1, 0, 0, '0);
    repeat (3) step(0, 0, 0, '0);
    // Three pushes, three pops.
    step(0, 1, 0, 32'h10); step(0, 1, 0, 32'h20); step(0, 1, 0, 32'h30);
    repeat (3) step(0, 0, 1, '0);
    // Underflow then push.
    step(0, 0, 1, '0);
    step(0, 1, 0, 32'h44);
    // Replace top.
    step(1, 0, 0, '0);
    step(0, 1, 0, 32'hA);
    step(0, 1, 1, 32'hB);
    step(0, 0, 1, '0);
    // Fill, push past full, drain.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 32'h100 + i);
    step(0, 1, 0, 32'h200);
    step(0, 1, 1, 32'h300);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    // Push+pop on empty.
    step(1, 0, 0, '0);
    step(0, 1, 1, 32'h99);
    // Reset wins over a simultaneous push.
    step(0, 1, 0, 32'h55); step(0, 1, 0, 32'h66);
    step(1, 1, 0, 32'h77);
    step(0, 0, 0, '0);
    // Randomized traffic with push-heavy and pop-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      int r;
      mode = (i / 60) % 3;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 199) == 0) step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      else if (mode == 0) step(0, r < 70, r >= 55 && r < 80, $urandom);
      else if (mode == 1) step(0, r < 25, r >= 15 && r < 75, $urandom);
      else step(0, r < 45, r >= 30 && r < 75, $urandom);
    end
    step(0, 0, 0, '0);
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", step_id, 64'(sb.size()), 64'd0);
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
